// File: rtl/hdmi_pat_pkg.sv
// Shared types, pattern/state encodings and small pixel helpers for the HDMI test-pattern sequencer.
package hdmi_pat_pkg;

    typedef logic [10:0] coord_t;
    typedef logic [15:0] rgb565_t;

    localparam logic [1:0] PAT_BARS   = 2'd0;
    localparam logic [1:0] PAT_GRAY   = 2'd1;
    localparam logic [1:0] PAT_CHECK  = 2'd2;
    localparam logic [1:0] PAT_BORDER = 2'd3;

    localparam logic [0:0] AUTO = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    // Green carries one extra LSB, kept at 0 so all three channels ramp together.
    function automatic rgb565_t gray565(input logic [4:0] l);
        return {l, l, 1'b0, l};
    endfunction

    function automatic logic [1:0] pat_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/hdmi_pattern_sequencer_if.sv
// Video timing in / pixel stream out bundle between the timing generator, the sequencer and the TMDS encoder.
interface hdmi_pattern_sequencer_if;
    import hdmi_pat_pkg::*;

    coord_t     i_x;
    coord_t     i_y;
    logic       i_hs;
    logic       i_vs;
    logic       i_de;
    logic       o_hs;
    logic       o_vs;
    logic       o_de;
    rgb565_t    o_data;
    logic [1:0] o_pat_idx;
    logic       o_hold;

    modport master (
        output i_x, i_y, i_hs, i_vs, i_de,
        input  o_hs, o_vs, o_de, o_data, o_pat_idx, o_hold
    );

    modport slave (
        input  i_x, i_y, i_hs, i_vs, i_de,
        output o_hs, o_vs, o_de, o_data, o_pat_idx, o_hold
    );

endinterface

// File: rtl/key_debounce.sv
// Synchronises and debounces an active-low push-button, classifying presses as short or long.
// Level change lands 2 + DEB_CYCLES cycles after the pin settles; pulses are registered, 1 cycle wide.
module key_debounce #(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 148_500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_short_p,
    output logic o_long_p
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [DW-1:0] r_deb_cnt;
    logic [LW-1:0] r_hold_cnt;
    logic          r_long_done;
    logic          r_short_p;
    logic          r_long_p;
    logic          w_db_chg;

    assign w_db_chg = (r_sync2 != r_db) && (r_deb_cnt == DEB_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_db        <= 1'b1;
            r_deb_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_short_p   <= 1'b0;
            r_long_p    <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;

            if (r_sync2 == r_db) begin
                r_deb_cnt <= '0;
            end else if (w_db_chg) begin
                r_deb_cnt <= '0;
                r_db      <= r_sync2;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end

            // A release only counts as a short press if the long press has not already fired.
            r_short_p <= w_db_chg && r_sync2 && !r_long_done;
            r_long_p  <= 1'b0;

            if (r_db) begin
                r_hold_cnt  <= '0;
                r_long_done <= 1'b0;
            end else if (!r_long_done) begin
                if (r_hold_cnt == LONG_LAST) begin
                    r_long_p    <= 1'b1;
                    r_long_done <= 1'b1;
                end else begin
                    r_hold_cnt <= r_hold_cnt + LW'(1);
                end
            end
        end
    end

    assign o_short_p = r_short_p;
    assign o_long_p  = r_long_p;

endmodule

// File: rtl/hdmi_pattern_sequencer.sv
// Registers video timing and overlays one of four RGB565 test patterns, auto-cycled or key-stepped.
// Latency 1 cycle i_* -> o_*; no backpressure, pattern index only changes on a frame edge.
module hdmi_pattern_sequencer
    import hdmi_pat_pkg::*;
#(
    parameter int H_ACTIVE       = 1920,
    parameter int V_ACTIVE       = 1080,
    parameter int FRAMES_PER_PAT = 120,
    parameter int DEB_CYCLES     = 1_000_000,
    parameter int LONG_CYCLES    = 148_500_000,
    parameter int CHECK_LOG2     = 6,
    parameter bit VS_POL         = 1'b1
) (
    input  logic                     rgb_clk,
    input  logic                     rgb_rst_n,
    input  logic                     key_n,
    hdmi_pattern_sequencer_if.slave  bus
);

    localparam int FC_W = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_PAT - 1);
    localparam coord_t X_LAST = coord_t'(H_ACTIVE - 1);
    localparam coord_t Y_LAST = coord_t'(V_ACTIVE - 1);

    logic            w_short_p;
    logic            w_long_p;
    logic            w_fe;
    logic            w_on_border;
    logic [3:0]      w_bar_k;
    rgb565_t         w_pix;

    logic            r_hs;
    logic            r_vs;
    logic            r_de;
    rgb565_t         r_data;
    logic [1:0]      r_idx;
    logic [0:0]      r_state;
    logic [FC_W-1:0] r_frame_cnt;
    logic            r_step_pend;

    key_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES)
    ) u_key (
        .i_clk     (rgb_clk),
        .i_rst_n   (rgb_rst_n),
        .i_key_n   (key_n),
        .o_short_p (w_short_p),
        .o_long_p  (w_long_p)
    );

    // r_vs is the previous i_vs, so this fires on the first active sample of vsync.
    assign w_fe = (bus.i_vs == VS_POL) && (r_vs != VS_POL);

    always_comb begin
        w_bar_k = '0;
        for (int j = 1; j < 16; j++) begin
            if (int'(bus.i_x) >= (H_ACTIVE / 16) * j) begin
                w_bar_k = w_bar_k + 4'd1;
            end
        end
    end

    assign w_on_border = (bus.i_x == '0) || (bus.i_x == X_LAST) ||
                         (bus.i_y == '0) || (bus.i_y == Y_LAST);

    always_comb begin
        w_pix = '0;
        case (r_idx)
            PAT_BARS:   w_pix = 16'h8000 >> w_bar_k;
            PAT_GRAY:   w_pix = gray565(bus.i_x[10:6]);
            PAT_CHECK:  w_pix = (bus.i_x[CHECK_LOG2] ^ bus.i_y[CHECK_LOG2]) ? 16'hFFFF : 16'h0000;
            PAT_BORDER: w_pix = w_on_border ? 16'hFFFF : 16'h0000;
            default:    w_pix = '0;
        endcase
    end

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
            r_de   <= 1'b0;
            r_data <= '0;
        end else begin
            r_hs   <= bus.i_hs;
            r_vs   <= bus.i_vs;
            r_de   <= bus.i_de;
            r_data <= bus.i_de ? w_pix : '0;
        end
    end

    // Key events take priority over the frame edge; a press landing on the edge steps at the next one.
    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            r_state     <= AUTO;
            r_idx       <= PAT_BARS;
            r_frame_cnt <= '0;
            r_step_pend <= 1'b0;
        end else if (r_state == AUTO) begin
            if (w_short_p) begin
                r_state     <= HOLD;
                r_frame_cnt <= '0;
            end else if (w_fe) begin
                if (r_frame_cnt == FC_LAST) begin
                    r_frame_cnt <= '0;
                    r_idx       <= pat_next(r_idx);
                end else begin
                    r_frame_cnt <= r_frame_cnt + FC_W'(1);
                end
            end
        end else begin
            if (w_long_p) begin
                r_state     <= AUTO;
                r_frame_cnt <= '0;
                r_step_pend <= 1'b0;
            end else begin
                if (w_fe && r_step_pend) begin
                    r_idx <= pat_next(r_idx);
                end
                r_step_pend <= (r_step_pend && !w_fe) || w_short_p;
            end
        end
    end

    assign bus.o_hs      = r_hs;
    assign bus.o_vs      = r_vs;
    assign bus.o_de      = r_de;
    assign bus.o_data    = r_data;
    assign bus.o_pat_idx = r_idx;
    assign bus.o_hold    = (r_state == HOLD);

endmodule

// File: tb/tb_hdmi_pattern_sequencer.sv
// Scoreboard bench for hdmi_pattern_sequencer: pixel path, auto cycling, key hold/step/long-press, reset.
module tb_hdmi_pattern_sequencer;

    localparam int H    = 32;
    localparam int V    = 8;
    localparam int FPP  = 3;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int CL   = 2;

    logic rgb_clk   = 1'b0;
    logic rgb_rst_n = 1'b0;
    logic key_n     = 1'b1;

    hdmi_pattern_sequencer_if bus();

    hdmi_pattern_sequencer #(
        .H_ACTIVE       (H),
        .V_ACTIVE       (V),
        .FRAMES_PER_PAT (FPP),
        .DEB_CYCLES     (DEB),
        .LONG_CYCLES    (LONG),
        .CHECK_LOG2     (CL),
        .VS_POL         (1'b1)
    ) dut (
        .rgb_clk   (rgb_clk),
        .rgb_rst_n (rgb_rst_n),
        .key_n     (key_n),
        .bus       (bus)
    );

    always #5 rgb_clk = ~rgb_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_idx   = 0;
    logic [18:0] sb_q[$];

    int gray_x[6]  = '{0, 63, 64, 127, 1000, 2047};
    int chk_x[7]   = '{0, 3, 4, 7, 8, 12, 31};
    int bord_x[7]  = '{0, 31, 5, 5, 5, 30, 31};
    int bord_y[7]  = '{3, 3, 0, 7, 3, 6, 7};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_pix(input int idx, input int x, input int y);
        int         k;
        logic [4:0] l;
        logic [15:0] r;
        r = 16'h0000;
        case (idx)
            0: begin
                k = x / (H / 16);
                if (k > 15) k = 15;
                r = 16'h8000 >> k;
            end
            1: begin
                l = 5'((x >> 6) & 31);
                r = {l, l, 1'b0, l};
            end
            2: r = ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: r = (x == 0 || x == H - 1 || y == 0 || y == V - 1) ? 16'hFFFF : 16'h0000;
        endcase
        return r;
    endfunction

    task automatic drive_pix(input int x, input int y, input bit de, input bit hs);
        @(negedge rgb_clk);
        bus.i_x  = 11'(x);
        bus.i_y  = 11'(y);
        bus.i_de = de;
        bus.i_hs = hs;
        bus.i_vs = 1'b0;
        sb_q.push_back({hs, 1'b0, de, de ? ref_pix(m_idx, x, y) : 16'h0000});
    endtask

    task automatic frame_edge();
        @(negedge rgb_clk);
        bus.i_de = 1'b0;
        bus.i_hs = 1'b0;
        bus.i_vs = 1'b1;
        @(negedge rgb_clk);
        bus.i_vs = 1'b0;
    endtask

    task automatic key_press(input int n);
        @(negedge rgb_clk);
        key_n = 1'b0;
        repeat (n) @(negedge rgb_clk);
        key_n = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge rgb_clk);
    endtask

    task automatic wait_hold(input logic v, input int budget, input string tag);
        for (int i = 0; i < budget && bus.o_hold !== v; i++) @(negedge rgb_clk);
        chk(tag, 32'(bus.o_hold), 32'(v));
    endtask

    always @(posedge rgb_clk) begin
        logic [18:0] exp;
        #1;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            chk("pix", {13'd0, bus.o_hs, bus.o_vs, bus.o_de, bus.o_data}, {13'd0, exp});
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_idx;
        bus.i_x  = '0;
        bus.i_y  = '0;
        bus.i_hs = 1'b0;
        bus.i_vs = 1'b0;
        bus.i_de = 1'b0;

        settle(3);
        chk("rst_hs",   32'(bus.o_hs), 0);
        chk("rst_vs",   32'(bus.o_vs), 0);
        chk("rst_de",   32'(bus.o_de), 0);
        chk("rst_data", 32'(bus.o_data), 0);
        chk("rst_idx",  32'(bus.o_pat_idx), 0);
        chk("rst_hold", 32'(bus.o_hold), 0);
        rgb_rst_n = 1'b1;

        // Bars across one line, then blanking forces zero data.
        m_idx = 0;
        for (int x = 0; x < H; x++) drive_pix(x, 0, 1'b1, x < 2);
        drive_pix(5, 0, 1'b0, 1'b0);
        drive_pix(31, 3, 1'b0, 1'b1);
        @(negedge rgb_clk);
        bus.i_de = 1'b0;
        bus.i_hs = 1'b0;

        chk("auto_idx_f0", 32'(bus.o_pat_idx), 0);
        for (int f = 1; f <= 12; f++) begin
            frame_edge();
            exp_idx = (f / FPP) % 4;
            chk($sformatf("auto_idx_f%0d", f), 32'(bus.o_pat_idx), 32'(exp_idx));
            m_idx = exp_idx;
            if (f == 3) foreach (gray_x[i]) drive_pix(gray_x[i], 2, 1'b1, 1'b0);
            if (f == 6) foreach (chk_x[i]) begin
                drive_pix(chk_x[i], 0, 1'b1, 1'b0);
                drive_pix(chk_x[i], 4, 1'b1, 1'b0);
            end
            if (f == 9) foreach (bord_x[i]) drive_pix(bord_x[i], bord_y[i], 1'b1, 1'b0);
        end
        @(negedge rgb_clk);
        bus.i_de = 1'b0;

        // Short press enters HOLD only once the release is debounced.
        key_press(6);
        chk("hold_before_release", 32'(bus.o_hold), 0);
        wait_hold(1'b1, 20, "hold_enter");
        chk("hold_idx_kept", 32'(bus.o_pat_idx), 0);

        key_press(2);
        settle(15);
        chk("glitch_hold", 32'(bus.o_hold), 1);
        frame_edge();
        chk("glitch_nostep", 32'(bus.o_pat_idx), 0);

        repeat (3) begin
            key_press(6);
            settle(10);
        end
        chk("multi_press_midframe", 32'(bus.o_pat_idx), 0);
        frame_edge();
        chk("multi_press_step", 32'(bus.o_pat_idx), 1);
        frame_edge();
        chk("multi_press_once", 32'(bus.o_pat_idx), 1);

        // Release timed so the short pulse lands on the frame-edge cycle.
        key_press(6);
        settle(5);
        frame_edge();
        chk("press_on_fe_defer", 32'(bus.o_pat_idx), 1);
        frame_edge();
        chk("press_on_fe_next", 32'(bus.o_pat_idx), 2);

        key_press(25);
        wait_hold(1'b0, 30, "long_exit");
        settle(15);
        chk("long_no_short", 32'(bus.o_hold), 0);
        chk("long_idx_kept", 32'(bus.o_pat_idx), 2);
        frame_edge();
        chk("restart_f1", 32'(bus.o_pat_idx), 2);
        frame_edge();
        chk("restart_f2", 32'(bus.o_pat_idx), 2);
        frame_edge();
        chk("restart_f3", 32'(bus.o_pat_idx), 3);

        // Asynchronous reset in the middle of active video.
        @(negedge rgb_clk);
        bus.i_x  = 11'd5;
        bus.i_y  = 11'd3;
        bus.i_de = 1'b1;
        @(negedge rgb_clk);
        rgb_rst_n = 1'b0;
        #1;
        chk("midrst_de",   32'(bus.o_de), 0);
        chk("midrst_data", 32'(bus.o_data), 0);
        chk("midrst_idx",  32'(bus.o_pat_idx), 0);
        chk("midrst_hold", 32'(bus.o_hold), 0);
        @(negedge rgb_clk);
        bus.i_de  = 1'b0;
        rgb_rst_n = 1'b1;
        m_idx = 0;
        drive_pix(6, 1, 1'b1, 1'b0);
        drive_pix(31, 1, 1'b1, 1'b0);
        @(negedge rgb_clk);
        bus.i_de = 1'b0;
        settle(3);
        chk("sb_drain", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
